// File: rtl/exp_3x3_ker_write_cont_pkg.sv
// Shared constants, FSM encoding and address helper for the EXPAND 3x3 kernel write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exp_3x3_ker_write_cont_pkg;

  localparam int EXP3_DATA_W     = 72;   // nine 8-bit weights per kernel word
  localparam int EXP3_HALF_DEPTH = 64;   // words per ping-pong half
  localparam int EXP3_L1_BASE    = 0;
  localparam int EXP3_L2_BASE    = 64;
  localparam int EXP3_ADDR_W     = 7;
  localparam int EXP3_WCNT_W     = 6;
  localparam int EXP3_LCNT_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FILL      = 2'd1,
    ST_WAIT_FREE = 2'd2,
    ST_DONE      = 2'd3
  } exp3_state_e;

  // Base of the selected half plus the word offset; halves never overlap because
  // the offset is only 6 bits wide.
  function automatic logic [EXP3_ADDR_W-1:0] exp3_wr_addr(input logic half,
                                                          input logic [EXP3_WCNT_W-1:0] wcnt);
    logic [EXP3_ADDR_W-1:0] base;
    base = half ? EXP3_ADDR_W'(EXP3_L2_BASE) : EXP3_ADDR_W'(EXP3_L1_BASE);
    return base | {1'b0, wcnt};
  endfunction

endpackage

// File: rtl/exp_3x3_ker_write_cont_if.sv
// Kernel-word stream from the kernel load path into the write controller.
// Latency: n/a (wires only).
// Backpressure: valid/ready; a word moves on a cycle where both are high.
interface exp_3x3_ker_write_cont_if
  import exp_3x3_ker_write_cont_pkg::*;
#(
  parameter int DATA_W = EXP3_DATA_W
) ();

  logic [DATA_W-1:0] ker_data_i;
  logic              ker_valid_i;
  logic              ker_ready_o;

  modport master (output ker_data_i, output ker_valid_i, input  ker_ready_o);
  modport slave  (input  ker_data_i, input  ker_valid_i, output ker_ready_o);

endinterface

// File: rtl/exp_3x3_ker_write_cont_layer_flag.sv
// Per-half "layer ready" flag: set when a layer is committed, cleared when the reader is done.
// Latency: 1 cycle from set/done/clear input to flag output.
// Backpressure: none; a done pulse while the flag is low is ignored.
module exp_3x3_layer_flag (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_all_i,
  input  logic set_i,
  input  logic done_i,
  output logic ready_o
);

  logic ready_d;
  logic ready_q;

  // Next flag value: global clear wins, then set, then reader done.
  always_comb begin
    ready_d = ready_q;
    if (clr_all_i) begin
      ready_d = 1'b0;
    end else if (set_i) begin
      ready_d = 1'b1;
    end else if (done_i) begin
      ready_d = 1'b0;
    end
  end

  // Flag register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;

endmodule

// File: rtl/exp_3x3_ker_write_cont.sv
// Fills the two halves of the EXPAND 3x3 kernel RAM alternately from a kernel-word stream.
// Latency: accepted word appears on the RAM write port 1 cycle later; ready flag 1 cycle after that.
// Backpressure: ker_ready_o drops while the target half still holds an unconsumed layer or when done.
module exp_3x3_ker_write_cont
  import exp_3x3_ker_write_cont_pkg::*;
#(
  parameter int DATA_W = EXP3_DATA_W
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [EXP3_WCNT_W-1:0] words_per_layer_i,
  input  logic [EXP3_LCNT_W-1:0] layer_count_i,
  exp_3x3_ker_write_cont_if.slave ker_if,
  output logic                   exp_3x3_ram_wr_en_o,
  output logic [EXP3_ADDR_W-1:0] exp_3x3_ram_wr_addr_o,
  output logic [DATA_W-1:0]      exp_3x3_ram_wr_data_o,
  output logic                   layer_1_ready_o,
  input  logic                   layer_1_done_i,
  output logic                   layer_2_ready_o,
  input  logic                   layer_2_done_i,
  output logic                   load_done_o
);

  exp3_state_e            state_d,     state_q;
  logic                   go_d,        go_q;
  logic                   half_d,      half_q;
  logic [EXP3_WCNT_W-1:0] word_cnt_d,  word_cnt_q;
  logic [EXP3_LCNT_W-1:0] layer_cnt_d, layer_cnt_q;
  logic                   wr_en_d,     wr_en_q;
  logic [EXP3_ADDR_W-1:0] wr_addr_d,   wr_addr_q;
  logic [DATA_W-1:0]      wr_data_d,   wr_data_q;
  logic                   wr_last_d,   wr_last_q;
  logic                   wr_final_d,  wr_final_q;
  logic                   load_done_d, load_done_q;

  logic l1_rdy;
  logic l2_rdy;
  logic l1_set;
  logic l2_set;
  logic tgt_ready;
  logic nxt_ready;
  logic ker_ready;
  logic accept;
  logic word_last;
  logic layer_last;

  assign tgt_ready  = half_q ? l2_rdy : l1_rdy;
  assign nxt_ready  = half_q ? l1_rdy : l2_rdy;
  assign ker_ready  = (state_q == ST_FILL) && !tgt_ready;
  assign accept     = ker_if.ker_valid_i && ker_ready;
  assign word_last  = (word_cnt_q == words_per_layer_i);
  assign layer_last = (layer_cnt_q == layer_count_i);

  // A half becomes readable only after its last word has actually been written.
  assign l1_set = wr_en_q && wr_last_q && !wr_addr_q[EXP3_ADDR_W-1];
  assign l2_set = wr_en_q && wr_last_q &&  wr_addr_q[EXP3_ADDR_W-1];

  // FSM, counters and write-stage next state; start_i overrides everything.
  always_comb begin
    state_d     = state_q;
    go_d        = 1'b0;
    half_d      = half_q;
    word_cnt_d  = word_cnt_q;
    layer_cnt_d = layer_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_last_d   = 1'b0;
    wr_final_d  = 1'b0;
    load_done_d = load_done_q || (wr_en_q && wr_final_q);

    case (state_q)
      ST_IDLE: begin
        if (go_q) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = exp3_wr_addr(half_q, word_cnt_q);
          wr_data_d = ker_if.ker_data_i;
          if (word_last) begin
            wr_last_d  = 1'b1;
            word_cnt_d = '0;
            if (layer_last) begin
              wr_final_d = 1'b1;
              state_d    = ST_DONE;
            end else begin
              layer_cnt_d = layer_cnt_q + 1'b1;
              half_d      = !half_q;
              if (nxt_ready) begin
                state_d = ST_WAIT_FREE;
              end
            end
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_FREE: begin
        if (!tgt_ready) begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_i) begin
      state_d     = ST_IDLE;
      go_d        = 1'b1;
      half_d      = 1'b0;
      word_cnt_d  = '0;
      layer_cnt_d = '0;
      wr_en_d     = 1'b0;
      wr_addr_d   = '0;
      wr_data_d   = '0;
      wr_last_d   = 1'b0;
      wr_final_d  = 1'b0;
      load_done_d = 1'b0;
    end
  end

  // State and write-stage registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      go_q        <= 1'b0;
      half_q      <= 1'b0;
      word_cnt_q  <= '0;
      layer_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_last_q   <= 1'b0;
      wr_final_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= go_d;
      half_q      <= half_d;
      word_cnt_q  <= word_cnt_d;
      layer_cnt_q <= layer_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_last_q   <= wr_last_d;
      wr_final_q  <= wr_final_d;
      load_done_q <= load_done_d;
    end
  end

  exp_3x3_layer_flag u_flag_l1 (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_all_i (start_i),
    .set_i     (l1_set),
    .done_i    (layer_1_done_i),
    .ready_o   (l1_rdy)
  );

  exp_3x3_layer_flag u_flag_l2 (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_all_i (start_i),
    .set_i     (l2_set),
    .done_i    (layer_2_done_i),
    .ready_o   (l2_rdy)
  );

  assign ker_if.ker_ready_o    = ker_ready;
  assign exp_3x3_ram_wr_en_o   = wr_en_q;
  assign exp_3x3_ram_wr_addr_o = wr_addr_q;
  assign exp_3x3_ram_wr_data_o = wr_data_q;
  assign layer_1_ready_o       = l1_rdy;
  assign layer_2_ready_o       = l2_rdy;
  assign load_done_o           = load_done_q;

endmodule

// File: tb/tb_exp_3x3_ker_write_cont.sv
// Scoreboard bench for the EXPAND 3x3 kernel write controller.
// Latency: n/a.
// Backpressure: random valid gaps and random reader done pulses.
module tb_exp_3x3_ker_write_cont;
  import exp_3x3_ker_write_cont_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  wpl;
  logic [6:0]  lc;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [71:0] wr_data;
  logic        l1r, l1d, l2r, l2d, load_done;

  always #5 clk = ~clk;

  exp_3x3_ker_write_cont_if #(.DATA_W(72)) ker_if ();

  exp_3x3_ker_write_cont #(.DATA_W(72)) dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .start_i               (start),
    .words_per_layer_i     (wpl),
    .layer_count_i         (lc),
    .ker_if                (ker_if.slave),
    .exp_3x3_ram_wr_en_o   (wr_en),
    .exp_3x3_ram_wr_addr_o (wr_addr),
    .exp_3x3_ram_wr_data_o (wr_data),
    .layer_1_ready_o       (l1r),
    .layer_1_done_i        (l1d),
    .layer_2_ready_o       (l2r),
    .layer_2_done_i        (l2d),
    .load_done_o           (load_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model + monitor ----------------
  typedef struct {
    logic [6:0]  addr;
    logic [71:0] data;
    bit          last;
    bit          fin;
    int          half;
  } exp_wr_t;

  exp_wr_t sbq[$];

  int cyc = 0;
  bit started = 0;
  int fill_from = 0;
  int acc_total = 0, acc_in_layer = 0, layer_idx = 0, total_words = 0;
  bit ef[2], pf[2], set_nx[2], clr_nx[2];
  bit done_nx = 0, ed = 0, start_pend = 0;
  int n_acc = 0, n_wr = 0;

  always @(negedge clk) begin
    exp_wr_t e;
    int tgt;
    bit exp_rdy;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", 128'({wr_en, wr_addr, wr_data, l1r, l2r, load_done, ker_if.ker_ready_o}), 128'(0));
      sbq.delete();
      started = 0; ed = 0; start_pend = 0; done_nx = 0;
      for (int h = 0; h < 2; h++) begin ef[h] = 0; pf[h] = 0; set_nx[h] = 0; clr_nx[h] = 0; end
    end else begin
      // events recorded last cycle take effect now
      if (start_pend) begin
        ef[0] = 0; ef[1] = 0; ed = 0; start_pend = 0;
      end else begin
        for (int h = 0; h < 2; h++) begin
          if (set_nx[h]) ef[h] = 1;
          else if (clr_nx[h]) ef[h] = 0;
        end
        if (done_nx) ed = 1;
      end
      for (int h = 0; h < 2; h++) begin set_nx[h] = 0; clr_nx[h] = 0; end
      done_nx = 0;

      // the loader may only take words while filling a free half; after moving onto
      // a half that was still full it needs one extra cycle once that half frees up
      tgt = layer_idx % 2;
      exp_rdy = started && (cyc >= fill_from) && (acc_total < total_words) && !ef[tgt] && !pf[tgt];
      chk("layer_1_ready", 128'(l1r), 128'(ef[0]));
      chk("layer_2_ready", 128'(l2r), 128'(ef[1]));
      chk("load_done", 128'(load_done), 128'(ed));
      chk("ker_ready", 128'(ker_if.ker_ready_o), 128'(exp_rdy));

      if (wr_en) begin
        n_wr++;
        if (sbq.size() == 0) begin
          chk("write_without_accept", 128'(1), 128'(0));
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", 128'(wr_addr), 128'(e.addr));
          chk("wr_data", 128'(wr_data), 128'(e.data));
          if (e.last) set_nx[e.half] = 1;
          if (e.fin) done_nx = 1;
        end
      end

      if (l1d && ef[0]) clr_nx[0] = 1;
      if (l2d && ef[1]) clr_nx[1] = 1;

      if (ker_if.ker_valid_i && ker_if.ker_ready_o && !start) begin
        e.half = layer_idx % 2;
        e.addr = 7'(e.half * 64 + acc_in_layer);
        e.data = ker_if.ker_data_i;
        e.last = (acc_in_layer == int'(wpl));
        e.fin  = e.last && (layer_idx == int'(lc));
        sbq.push_back(e);
        acc_total++;
        n_acc++;
        if (e.last) begin acc_in_layer = 0; layer_idx++; end
        else acc_in_layer++;
      end

      if (start) begin
        start_pend = 1;
        started = 1;
        fill_from = cyc + 2;
        acc_total = 0; acc_in_layer = 0; layer_idx = 0;
        total_words = (int'(wpl) + 1) * (int'(lc) + 1);
        for (int h = 0; h < 2; h++) begin set_nx[h] = 0; clr_nx[h] = 0; end
        done_nx = 0;
      end

      pf[0] = ef[0]; pf[1] = ef[1];
    end
  end

  // ---------------- stimulus ----------------
  bit v_always = 1;
  int v_pct = 100;
  bit rnd_done = 0;
  int d_pct = 0;

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    ker_if.ker_valid_i = v_always || ($urandom_range(99) < v_pct);
    ker_if.ker_data_i  = 72'({$urandom(), $urandom(), $urandom()});
    l1d = rnd_done && ($urandom_range(99) < d_pct);
    l2d = rnd_done && ($urandom_range(99) < d_pct);
  endtask

  task automatic do_start();
    step();
    start = 1'b1;
    step();
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (!load_done && n < budget) begin step(); n++; end
    chk(name, 128'(load_done), 128'(1));
  endtask

  task automatic wait_addr(input logic [6:0] a, input int budget, input string name);
    int n = 0;
    while (!(wr_en && wr_addr == a) && n < budget) begin step(); n++; end
    chk(name, 128'(wr_en && wr_addr == a), 128'(1));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 128'({wr_en, wr_addr, wr_data, l1r, l2r, load_done, ker_if.ker_ready_o}), 128'(0));
  endtask

  initial begin
    int n, a0, w0;
    rst_n = 1'b0; start = 1'b0; wpl = 6'd3; lc = 7'd1;
    l1d = 1'b0; l2d = 1'b0;
    ker_if.ker_valid_i = 1'b0; ker_if.ker_data_i = '0;
    repeat (3) step();
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    step(); step(); step();
    chk("idle_without_start", 128'(ker_if.ker_ready_o), 128'(0));

    // 1: two layers of four words, valid always high
    wpl = 6'd3; lc = 7'd1; v_always = 1; rnd_done = 0;
    do_start();
    run_until_done(100, "t1_load_done");
    step();
    chk("t1_both_halves_ready", 128'({l1r, l2r}), 128'(2'b11));

    // 2: third layer must wait for half 1 to be freed
    wpl = 6'd3; lc = 7'd2;
    do_start();
    n = 0;
    while (!(l1r && l2r) && n < 100) begin step(); n++; end
    chk("t2_halves_full", 128'({l1r, l2r}), 128'(2'b11));
    repeat (5) step();
    chk("t2_wait_free_stall", 128'(ker_if.ker_ready_o), 128'(0));
    l1d = 1'b1;
    step();
    chk("t2_flag_cleared", 128'(l1r), 128'(0));
    chk("t2_still_stalled", 128'(ker_if.ker_ready_o), 128'(0));
    step();
    chk("t2_ready_returns", 128'(ker_if.ker_ready_o), 128'(1));
    run_until_done(100, "t2_load_done");

    // 4: done on half 2 coincides with half 1 becoming ready
    wpl = 6'd3; lc = 7'd1;
    do_start();
    wait_addr(7'd3, 100, "t4_reach_addr3");
    l2d = 1'b1;
    step();
    chk("t4_flags", 128'({l1r, l2r}), 128'(2'b10));
    run_until_done(100, "t4_load_done");

    // 3: random valid gaps and random reader activity
    v_always = 0; v_pct = 60; rnd_done = 1; d_pct = 20;
    for (int it = 0; it < 4; it++) begin
      wpl = 6'($urandom_range(0, 7));
      lc  = 7'($urandom_range(0, 5));
      do_start();
      a0 = n_acc; w0 = n_wr;
      run_until_done(3000, "t3_load_done");
      chk("t3_write_count", 128'(n_wr - w0), 128'(n_acc - a0));
      chk("t3_accept_count", 128'(n_acc - a0), 128'((int'(wpl) + 1) * (int'(lc) + 1)));
    end
    v_always = 1; rnd_done = 0;

    // 5: async reset, then start_i, both in the middle of a fill
    wpl = 6'd3; lc = 7'd3;
    do_start();
    wait_addr(7'd66, 100, "t5_reach_addr66_a");
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async_reset");
    step(); step();
    rst_n = 1'b1;
    do_start();
    wait_addr(7'd66, 100, "t5_reach_addr66_b");
    start = 1'b1;
    step();
    chk_all_zero("t5_start_clear");
    n = 0;
    while (!wr_en && n < 20) begin step(); n++; end
    chk("t5_restart_addr", 128'({wr_en, wr_addr}), 128'({1'b1, 7'd0}));
    rnd_done = 1; d_pct = 30;
    run_until_done(500, "t5_load_done");
    rnd_done = 0;

    // 6: full 64-word layers
    wpl = 6'd63; lc = 7'd1;
    do_start();
    wait_addr(7'd63, 200, "t6_reach_addr63");
    step();
    chk("t6_next_addr", 128'({wr_en, wr_addr}), 128'({1'b1, 7'd64}));
    run_until_done(300, "t6_load_done");
    step();
    chk("t6_scoreboard_empty", 128'(sbq.size()), 128'(0));

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
